oled_pixel_streamer: RTL and testbench

//  Scans the 96x64 OLED raster and drives the x/y coordinates into a combinational

---
 rtl/oled_pixel_streamer.sv | 196 +++++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_pixel_streamer.sv
// -----------------------------------------------------------------------------
// oled_pixel_streamer
//   Walks the WIDTH x HEIGHT OLED raster and presents each (x, y) to a
//   combinational screen renderer. One clock later it captures the renderer's
//   RGB565 word and sends it MSB first over a write-only SPI link in mode 0
//   (SCLK idles low, MOSI changes on the falling edge). One full frame is sent
//   for each frame_start accepted while idle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_start  single-cycle request for one frame (ignored unless idle)
//   x, y         registered raster coordinate driven to the renderer
//   pixel_index  registered y*WIDTH+x
//   oled_data    RGB565 colour returned by the renderer for (x, y)
//   spi_cs_n     chip select, held low for the whole frame
//   spi_sclk     serial clock, idles low
//   spi_mosi     serial data
//   spi_dc       data/command select, always 1 (pixel data)
//   frame_busy   high from the accepted frame_start until the end of DONE
//   frame_done   one-cycle pulse after the last bit of the last pixel
// -----------------------------------------------------------------------------
module oled_pixel_streamer #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [12:0] pixel_index,
  input  logic [15:0] oled_data,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_dc,
  output logic        frame_busy,
  output logic        frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]      X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0]      Y_LAST   = 6'(HEIGHT - 1);

  logic [2:0]       state_q, state_d;
  logic [6:0]       x_q, x_d;
  logic [5:0]       y_q, y_d;
  logic [12:0]      pix_q, pix_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_pixel;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = pix_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          pix_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      // x/y have been stable for this whole cycle, so the renderer output is
      // valid at its end. MSB goes onto MOSI now so it is settled for a full
      // low phase before the first rising edge.
      S_LOAD: begin
        shift_d = oled_data;
        mosi_d  = oled_data[15];
        bit_d   = 4'd15;
        div_d   = '0;
        sclk_d  = 1'b0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // falling edge: either advance to the next bit or finish the word
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = last_pixel ? S_DONE : S_NEXT;
              done_d  = last_pixel;
            end else begin
              bit_d   = bit_q - 4'd1;
              shift_d = {shift_q[14:0], 1'b0};
              mosi_d  = shift_q[14];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_NEXT: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 6'd1;
        end else begin
          x_d = x_q + 7'd1;
        end
        pix_d   = pix_q + 13'd1;
        state_d = S_LOAD;
      end

      S_DONE: begin
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;
        pix_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_index = pix_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_dc      = 1'b1;
  assign frame_busy  = busy_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_oled_pixel_streamer
//   Scoreboard bench on a reduced raster. Each accepted frame pushes the full
//   raster-order list of expected words; a negedge monitor deserialises MOSI on
//   every SCLK rising edge and pops/compares, and also checks SCLK phase
//   lengths, MOSI setup/hold, chip select and the frame_done/busy timing.
//   The renderer model is oled_data = {3'b0, x, y} ^ key, with random noise
//   injected whenever the streamer is mid-word (which must not matter).
// -----------------------------------------------------------------------------
module tb_oled_pixel_streamer;

  localparam int W       = 12;
  localparam int H       = 5;
  localparam int D       = 2;
  localparam int PIX_CYC = 2 + 32 * D;
  localparam int FRAME_CYC = W * H * PIX_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [12:0] pixel_index;
  logic [15:0] oled_data = 16'h0;
  logic        spi_cs_n, spi_sclk, spi_mosi, spi_dc, frame_busy, frame_done;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] key = 16'h0;
  bit          glitch_en = 1'b0;
  int          done_cnt = 0;

  // monitor state
  int          bitcnt = 0;
  logic [15:0] word = 16'h0;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_done = 1'b0;
  logic        mosi_at_rise = 1'b0;
  int          hi_len = 0;
  int          lo_len = 0;
  int          mosi_age = 0;
  int          busy_len = 0;

  always #5 clk = ~clk;

  oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .x(x), .y(y), .pixel_index(pixel_index), .oled_data(oled_data),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [15:0] k);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back({3'b000, 7'(xx), 6'(yy)} ^ k);
  endtask

  // monitor / scoreboard / renderer model
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bitcnt    = 0;
      prev_sclk = 1'b0;
      prev_done = 1'b0;
      hi_len    = 0;
      lo_len    = 0;
      mosi_age  = 0;
      busy_len  = 0;
      oled_data = {3'b000, x, y} ^ key;
    end else begin
      if (frame_busy) busy_len++;
      if (spi_mosi !== prev_mosi) mosi_age = 1; else mosi_age++;
      if (spi_sclk) hi_len++; else lo_len++;

      if (spi_sclk && !prev_sclk) begin
        check("cs_low_at_rise", spi_cs_n, 1'b0);
        check("dc_at_rise", spi_dc, 1'b1);
        check("pixel_index", pixel_index, y * W + x);
        check("sclk_low_phase_min", (lo_len >= D), 1'b1);
        check("mosi_setup", (mosi_age >= D + 1), 1'b1);
        lo_len       = 0;
        mosi_at_rise = spi_mosi;
        word         = {word[14:0], spi_mosi};
        bitcnt++;
        if (bitcnt == 16) begin
          bitcnt = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL word_unexpected: got %0h, expected no word (t=%0t)", word, $time);
          end else begin
            check("pixel_word", word, exp_q.pop_front());
          end
        end
      end else if (spi_sclk) begin
        check("mosi_hold_high", spi_mosi, mosi_at_rise);
      end

      if (!spi_sclk && prev_sclk) begin
        check("sclk_high_phase", hi_len, D);
        hi_len = 0;
      end

      if (frame_done) begin
        check("done_single_cycle", prev_done, 1'b0);
        check("done_while_busy", frame_busy, 1'b1);
        check("done_queue_empty", exp_q.size(), 0);
        check("done_word_aligned", bitcnt, 0);
        check("frame_cycles", busy_len, FRAME_CYC);
        busy_len = 0;
        done_cnt++;
      end

      prev_sclk = spi_sclk;
      prev_done = frame_done;
      oled_data = {3'b000, x, y} ^ key ^
                  ((glitch_en && bitcnt != 0) ? 16'($urandom) : 16'h0);
    end
    prev_mosi = spi_mosi;
  end

  task automatic start_frame(input logic [15:0] k);
    @(negedge clk);
    key = k;
    push_frame(k);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (frame_busy === 1'b1 && c < FRAME_CYC + 50) begin
      @(negedge clk);
      c++;
    end
    check(name, (c < FRAME_CYC + 50), 1'b1);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int c;
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_dc", spi_dc, 1'b1);
    check("rst_busy", frame_busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_x", x, 7'd0);
    check("rst_y", y, 6'd0);
    check("rst_pixel_index", pixel_index, 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // frame 1: fixed colour pattern
    glitch_en = 1'b0;
    start_frame(16'hA5C3);
    wait_idle("frame1_complete");
    repeat (3) @(negedge clk);

    // frame 2: random key, noisy renderer, stray frame_start mid-frame and in DONE
    glitch_en = 1'b1;
    start_frame(16'($urandom));
    repeat (500) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    c = 0;
    while (frame_done !== 1'b1 && c < FRAME_CYC + 50) begin
      @(negedge clk);
      c++;
    end
    check("frame2_done_seen", (c < FRAME_CYC + 50), 1'b1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_falls_with_done", frame_busy, 1'b0);
    repeat (3 * PIX_CYC) @(negedge clk);
    check("no_second_frame_busy", frame_busy, 1'b0);
    check("no_second_frame_cs", spi_cs_n, 1'b1);
    check("frame2_done_count", done_cnt, 2);

    // frame 3: reset asserted during bit 7 of pixel (10,3)
    start_frame(16'($urandom));
    c = 0;
    while (!(x == 7'd10 && y == 6'd3) && c < FRAME_CYC) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("reach_pixel_10_3", (c < FRAME_CYC), 1'b1);
    c = 0;
    while (bitcnt != 8 && c < PIX_CYC) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("reach_bit7", (c < PIX_CYC), 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", spi_cs_n, 1'b1);
    check("midrst_sclk", spi_sclk, 1'b0);
    check("midrst_mosi", spi_mosi, 1'b0);
    check("midrst_busy", frame_busy, 1'b0);
    check("midrst_x", x, 7'd0);
    check("midrst_y", y, 6'd0);
    check("midrst_pixel_index", pixel_index, 13'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // frame 4: plain {x,y} renderer, must restart at (0,0)
    start_frame(16'h0000);
    wait_idle("frame4_complete");
    repeat (3) @(negedge clk);

    check("total_done_pulses", done_cnt, 3);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
